// File: rtl/ptp_event_parser_if.sv
// Packet-stream tap from the MAC side plus the report bundle for the TSU timestamp queue.
// The stream generator uses master; ptp_event_parser uses slave.
interface ptp_event_parser_if #(
  parameter int unsigned TIME_W = 30
);
  logic [31:0]          ptp_data;
  logic                 ptp_valid;
  logic                 ptp_sop;
  logic                 ptp_eop;
  logic [1:0]           ptp_mod;
  logic [TIME_W-1:0]    ptp_time;
  logic                 ptp_found;
  logic [1:0]           ptp_encap;
  logic [20+TIME_W-1:0] ptp_infor;

  modport master (
    output ptp_data, ptp_valid, ptp_sop, ptp_eop, ptp_mod, ptp_time,
    input  ptp_found, ptp_encap, ptp_infor
  );

  modport slave (
    input  ptp_data, ptp_valid, ptp_sop, ptp_eop, ptp_mod, ptp_time,
    output ptp_found, ptp_encap, ptp_infor
  );
endinterface

// File: rtl/ptp_event_parser.sv
// Classifies frames on a 32-bit SOP/EOP stream as PTP event frames (L2 or IPv4/UDP behind VLAN tags)
// and pulses ptp_found with {msgid, seqid, SOP time}. Define PTP_IPV6_EN to also accept IPv6/UDP.
module ptp_event_parser #(
  parameter int unsigned TIME_W   = 30,
  parameter int unsigned MAX_VLAN = 2,
  parameter logic [15:0] MSG_MASK = 16'h000F,
  parameter logic [15:0] UDP_PORT = 16'd319
) (
  input logic               clk,
  input logic               rst,
  ptp_event_parser_if.slave bus
);

  typedef enum logic [2:0] {IDLE, ETYPE, L2, IP4, IP6, MATCH, DROP} state_t;

  localparam logic [1:0] VLAN_LIM = 2'(MAX_VLAN);

  state_t              state_q, state_d;
  logic [5:0]          wcnt_q, wcnt_d;
  logic [1:0]          vlan_q, vlan_d;
  logic [3:0]          msgid_q, msgid_d;
  logic [15:0]         seqid_q, seqid_d;
  logic [TIME_W-1:0]   time_q, time_d;
  logic [1:0]          kind_q, kind_d;
  logic                found_q, found_d;
  logic [1:0]          encap_q, encap_d;
  logic [20+TIME_W-1:0] infor_q, infor_d;

  state_t      cur_st;
  logic [1:0]  cur_vlan;
  logic [5:0]  cur_w;
  logic [5:0]  e_w;
  logic [15:0] hi;
  logic [7:0]  b1;
  logic [7:0]  b0;
  logic        unused_mod;

  assign unused_mod = ^bus.ptp_mod;
  assign hi = bus.ptp_data[31:16];
  assign b1 = bus.ptp_data[15:8];
  assign b0 = bus.ptp_data[7:0];

  // cur_* describe the parse as seen by the current word, i.e. after a SOP restart if there is one.
  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    vlan_d   = vlan_q;
    msgid_d  = msgid_q;
    seqid_d  = seqid_q;
    time_d   = time_q;
    kind_d   = kind_q;
    found_d  = 1'b0;
    encap_d  = 2'b00;
    infor_d  = '0;
    cur_st   = state_q;
    cur_vlan = vlan_q;
    cur_w    = wcnt_q;
    e_w      = 6'd3 + {4'd0, vlan_q};

    if (bus.ptp_valid) begin
      if (bus.ptp_sop) begin
        cur_st   = ETYPE;
        cur_vlan = 2'd0;
        cur_w    = 6'd0;
        wcnt_d   = 6'd1;
        time_d   = bus.ptp_time;
        msgid_d  = 4'd0;
        seqid_d  = 16'd0;
        kind_d   = 2'b00;
      end else if (wcnt_q != 6'd63) begin
        wcnt_d = wcnt_q + 6'd1;
      end
      e_w     = 6'd3 + {4'd0, cur_vlan};
      state_d = cur_st;
      vlan_d  = cur_vlan;

      case (cur_st)
        ETYPE: begin
          if (cur_w == e_w) begin
            if (hi == 16'h8100 || hi == 16'h88A8) begin
              if (cur_vlan < VLAN_LIM) vlan_d = cur_vlan + 2'd1;
              else                     state_d = DROP;
            end else if (hi == 16'h88F7) begin
              state_d = L2;
              kind_d  = 2'b01;
              msgid_d = bus.ptp_data[11:8];
            end else if (hi == 16'h0800) begin
              // The IPv4 version/IHL byte shares the ethertype word.
              if (b1 == 8'h45) begin
                state_d = IP4;
                kind_d  = 2'b10;
              end else begin
                state_d = DROP;
              end
`ifdef PTP_IPV6_EN
            end else if (hi == 16'h86DD) begin
              state_d = IP6;
              kind_d  = 2'b11;
`endif
            end else begin
              state_d = DROP;
            end
          end
        end
        L2: begin
          if (cur_w == e_w + 6'd8) begin
            seqid_d = hi;
            state_d = MATCH;
          end
        end
        IP4: begin
          if (cur_w == e_w + 6'd2 && b0 != 8'h11)            state_d = DROP;
          else if (cur_w == e_w + 6'd6 && hi != UDP_PORT)    state_d = DROP;
          else if (cur_w == e_w + 6'd7)                      msgid_d = bus.ptp_data[11:8];
          else if (cur_w == e_w + 6'd15) begin
            seqid_d = hi;
            state_d = MATCH;
          end
        end
`ifdef PTP_IPV6_EN
        IP6: begin
          if (cur_w == e_w + 6'd2 && bus.ptp_data[31:24] != 8'h11) state_d = DROP;
          else if (cur_w == e_w + 6'd11 && hi != UDP_PORT)         state_d = DROP;
          else if (cur_w == e_w + 6'd12)                           msgid_d = bus.ptp_data[11:8];
          else if (cur_w == e_w + 6'd20) begin
            seqid_d = hi;
            state_d = MATCH;
          end
        end
`endif
        default: ;
      endcase

      // Only a frame already in MATCH before its EOP word reports; a SOP on that word starts over.
      if (bus.ptp_eop) begin
        state_d = IDLE;
        if (!bus.ptp_sop && state_q == MATCH && MSG_MASK[msgid_q]) begin
          found_d = 1'b1;
          encap_d = kind_q;
          infor_d = {msgid_q, seqid_q, time_q};
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wcnt_q  <= 6'd0;
      vlan_q  <= 2'd0;
      msgid_q <= 4'd0;
      seqid_q <= 16'd0;
      time_q  <= '0;
      kind_q  <= 2'b00;
      found_q <= 1'b0;
      encap_q <= 2'b00;
      infor_q <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      vlan_q  <= vlan_d;
      msgid_q <= msgid_d;
      seqid_q <= seqid_d;
      time_q  <= time_d;
      kind_q  <= kind_d;
      found_q <= found_d;
      encap_q <= encap_d;
      infor_q <= infor_d;
    end
  end

  assign bus.ptp_found = found_q;
  assign bus.ptp_encap = encap_q;
  assign bus.ptp_infor = infor_q;

endmodule

// File: tb/tb_ptp_event_parser.sv
// Directed bench for ptp_event_parser: builds frames byte by byte, drives them as 32-bit words
// and checks pulse timing, payload and count; IPv6 expectations follow PTP_IPV6_EN.
module tb_ptp_event_parser;

  localparam int TIME_W = 30;

  typedef struct {
    int                kind;      // 0 other ethertype, 1 L2, 2 IPv4, 3 IPv6
    int                ntags;
    logic [15:0]       tag0, tag1, tag2;
    logic [7:0]        vihl;
    logic [7:0]        proto;
    logic [15:0]       port;
    logic [3:0]        msgid;
    logic [15:0]       seqid;
    logic [TIME_W-1:0] t0;
    int                gap_max;
    bit                exp_found;
    logic [1:0]        exp_encap;
  } vec_t;

  logic clk = 1'b0;
  logic rst;

  ptp_event_parser_if #(.TIME_W(TIME_W)) bus ();

  ptp_event_parser dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int pulse_cnt = 0;

  always @(posedge clk) if (bus.ptp_found === 1'b1) pulse_cnt++;

  logic [7:0]  fb [0:127];
  logic [31:0] fw [0:31];
  int          nw;
  vec_t        vecs [12];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int kind, input int ntags, input logic [15:0] tag0,
                              input logic [15:0] tag1, input logic [15:0] tag2,
                              input logic [7:0] vihl, input logic [7:0] proto,
                              input logic [15:0] port, input logic [3:0] msgid,
                              input logic [15:0] seqid, input logic [TIME_W-1:0] t0,
                              input int gap_max, input bit exp_found, input logic [1:0] exp_encap);
    vec_t v;
    v.kind = kind; v.ntags = ntags; v.tag0 = tag0; v.tag1 = tag1; v.tag2 = tag2;
    v.vihl = vihl; v.proto = proto; v.port = port; v.msgid = msgid; v.seqid = seqid;
    v.t0 = t0; v.gap_max = gap_max; v.exp_found = exp_found; v.exp_encap = exp_encap;
    return v;
  endfunction

  task automatic buildFrame(input vec_t v);
    int l3;
    int p;
    int len;
    logic [15:0] tag;
    logic [15:0] et;
    for (int i = 0; i < 128; i++) fb[i] = 8'(i * 37 + 11);
    fb[0] = 8'h01; fb[1] = 8'h1B; fb[2] = 8'h19; fb[3] = 8'h00; fb[4] = 8'h00; fb[5] = 8'h00;
    l3 = 12;
    for (int t = 0; t < v.ntags; t++) begin
      tag = (t == 0) ? v.tag0 : (t == 1) ? v.tag1 : v.tag2;
      fb[l3] = tag[15:8]; fb[l3+1] = tag[7:0]; fb[l3+2] = 8'h00; fb[l3+3] = 8'h05;
      l3 += 4;
    end
    case (v.kind)
      1:       et = 16'h88F7;
      2:       et = 16'h0800;
      3:       et = 16'h86DD;
      default: et = 16'h0806;
    endcase
    fb[l3] = et[15:8]; fb[l3+1] = et[7:0];
    l3 += 2;
    case (v.kind)
      2: begin
        fb[l3] = v.vihl; fb[l3+9] = v.proto;
        fb[l3+22] = v.port[15:8]; fb[l3+23] = v.port[7:0];
        p = l3 + 28;
      end
      3: begin
        fb[l3] = 8'h60; fb[l3+6] = v.proto;
        fb[l3+42] = v.port[15:8]; fb[l3+43] = v.port[7:0];
        p = l3 + 48;
      end
      default: p = l3;
    endcase
    fb[p] = {4'h0, v.msgid};
    fb[p+30] = v.seqid[15:8];
    fb[p+31] = v.seqid[7:0];
    len = p + 44 + 4;
    nw = (len + 3) / 4;
    for (int i = 0; i < nw; i++) fw[i] = {fb[4*i], fb[4*i+1], fb[4*i+2], fb[4*i+3]};
  endtask

  task automatic driveWord(input logic [31:0] d, input bit sop, input bit eop, input logic [TIME_W-1:0] t);
    @(negedge clk);
    bus.ptp_valid = 1'b1;
    bus.ptp_data  = d;
    bus.ptp_sop   = sop;
    bus.ptp_eop   = eop;
    bus.ptp_mod   = 2'd0;
    bus.ptp_time  = t;
  endtask

  task automatic idleCycle();
    @(negedge clk);
    bus.ptp_valid = 1'b0;
    bus.ptp_sop   = 1'b0;
    bus.ptp_eop   = 1'b0;
    bus.ptp_data  = 32'h0;
    bus.ptp_time  = bus.ptp_time + 30'd3;
  endtask

  // Stalled cycles carry junk including sop/eop so that ignoring them is actually exercised.
  task automatic junkCycle();
    @(negedge clk);
    bus.ptp_valid = 1'b0;
    bus.ptp_sop   = 1'b1;
    bus.ptp_eop   = 1'b1;
    bus.ptp_data  = $urandom;
    bus.ptp_time  = TIME_W'($urandom);
  endtask

  task automatic driveRange(input int first, input int last, input int eop_at, input int gap,
                            input logic [TIME_W-1:0] t0);
    for (int i = first; i <= last; i++) begin
      if (gap > 0) repeat ($urandom_range(0, gap)) junkCycle();
      driveWord(fw[i], i == 0, i == eop_at, (i == 0) ? t0 : t0 + TIME_W'(i * 13 + 5));
    end
  endtask

  task automatic finishFrame(input string name, input bit exp_found, input logic [1:0] exp_encap,
                             input logic [63:0] exp_infor, input int base, input int exp_pulses);
    idleCycle();
    checkOutput({name, " found"}, {63'd0, bus.ptp_found}, {63'd0, exp_found});
    checkOutput({name, " encap"}, {62'd0, bus.ptp_encap}, {62'd0, exp_encap});
    checkOutput({name, " infor"}, {14'd0, bus.ptp_infor}, exp_infor);
    idleCycle();
    checkOutput({name, " width"}, {63'd0, bus.ptp_found}, 64'd0);
    idleCycle();
    checkOutput({name, " count"}, 64'(pulse_cnt - base), 64'(exp_pulses));
  endtask

  task automatic applyStimulus(input int idx, input vec_t v);
    int base;
    logic [63:0] exp_infor;
    buildFrame(v);
    base = pulse_cnt;
    driveRange(0, nw - 1, nw - 1, v.gap_max, v.t0);
    exp_infor = v.exp_found ? {14'd0, v.msgid, v.seqid, v.t0} : 64'd0;
    finishFrame($sformatf("v%0d", idx), v.exp_found, v.exp_found ? v.exp_encap : 2'b00,
                exp_infor, base, v.exp_found ? 1 : 0);
  endtask

  initial begin
    vec_t va;
    vec_t vb;
    int base;
    bit ip6_on;
`ifdef PTP_IPV6_EN
    ip6_on = 1'b1;
`else
    ip6_on = 1'b0;
`endif

    vecs[0]  = mk(2, 0, 16'h0, 16'h0, 16'h0, 8'h45, 8'h11, 16'd319, 4'h0, 16'hA5C3, 30'h1234, 0, 1, 2'b10);
    vecs[1]  = mk(1, 2, 16'h88A8, 16'h8100, 16'h0, 8'h00, 8'h00, 16'd0, 4'h2, 16'h0102, 30'h0ABCDE, 0, 1, 2'b01);
    vecs[2]  = mk(1, 3, 16'h88A8, 16'h8100, 16'h8100, 8'h00, 8'h00, 16'd0, 4'h2, 16'h0102, 30'h0ABCDE, 0, 0, 2'b00);
    vecs[3]  = mk(2, 0, 16'h0, 16'h0, 16'h0, 8'h45, 8'h11, 16'd319, 4'h8, 16'h1111, 30'h2000, 0, 0, 2'b00);
    vecs[4]  = mk(2, 0, 16'h0, 16'h0, 16'h0, 8'h45, 8'h11, 16'd320, 4'h0, 16'h2222, 30'h3000, 0, 0, 2'b00);
    vecs[5]  = mk(2, 0, 16'h0, 16'h0, 16'h0, 8'h46, 8'h11, 16'd319, 4'h0, 16'h3333, 30'h4000, 0, 0, 2'b00);
    vecs[6]  = mk(2, 0, 16'h0, 16'h0, 16'h0, 8'h45, 8'h06, 16'd319, 4'h0, 16'h4444, 30'h5000, 0, 0, 2'b00);
    vecs[7]  = mk(3, 0, 16'h0, 16'h0, 16'h0, 8'h00, 8'h11, 16'd319, 4'h2, 16'hBEEF, 30'h6000, 0, ip6_on, 2'b11);
    vecs[8]  = mk(1, 0, 16'h0, 16'h0, 16'h0, 8'h00, 8'h00, 16'd0, 4'h3, 16'hFFFF, 30'h3FFFFFFF, 0, 1, 2'b01);
    vecs[9]  = mk(2, 0, 16'h0, 16'h0, 16'h0, 8'h45, 8'h11, 16'd319, 4'h0, 16'h1357, 30'h0777, 3, 1, 2'b10);
    vecs[10] = mk(2, 1, 16'h8100, 16'h0, 16'h0, 8'h45, 8'h11, 16'd319, 4'h1, 16'h2468, 30'h1A2B3C, 0, 1, 2'b10);
    vecs[11] = mk(0, 0, 16'h0, 16'h0, 16'h0, 8'h45, 8'h11, 16'd319, 4'h0, 16'h5555, 30'h7000, 0, 0, 2'b00);

    rst = 1'b1;
    bus.ptp_valid = 1'b0; bus.ptp_sop = 1'b0; bus.ptp_eop = 1'b0;
    bus.ptp_data = 32'h0; bus.ptp_mod = 2'd0; bus.ptp_time = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset found", {63'd0, bus.ptp_found}, 64'd0);
    checkOutput("reset encap", {62'd0, bus.ptp_encap}, 64'd0);
    checkOutput("reset infor", {14'd0, bus.ptp_infor}, 64'd0);
    rst = 1'b0;
    idleCycle();

    for (int i = 0; i < 12; i++) applyStimulus(i, vecs[i]);

    // A new SOP at w=10 abandons the first frame; only the second reports, with its own SOP time.
    va = vecs[0]; va.seqid = 16'h1111; va.t0 = 30'h0111;
    vb = vecs[0]; vb.seqid = 16'h2222; vb.t0 = 30'h0222;
    base = pulse_cnt;
    buildFrame(va);
    driveRange(0, 10, -1, 0, va.t0);
    buildFrame(vb);
    driveRange(0, nw - 1, nw - 1, 0, vb.t0);
    finishFrame("abort", 1'b1, 2'b10, {14'd0, 4'h0, 16'h2222, 30'h0222}, base, 1);

    // Back-to-back: SOP of the second frame right after the first frame's EOP.
    va = vecs[8]; va.seqid = 16'h0A0A; va.t0 = 30'h00AA;
    vb = vecs[0]; vb.seqid = 16'h0B0B; vb.t0 = 30'h00BB;
    base = pulse_cnt;
    buildFrame(va);
    driveRange(0, nw - 1, nw - 1, 0, va.t0);
    buildFrame(vb);
    driveWord(fw[0], 1'b1, 1'b0, vb.t0);
    checkOutput("b2b first found", {63'd0, bus.ptp_found}, 64'd1);
    checkOutput("b2b first encap", {62'd0, bus.ptp_encap}, 64'd1);
    checkOutput("b2b first infor", {14'd0, bus.ptp_infor}, {14'd0, 4'h3, 16'h0A0A, 30'h00AA});
    driveRange(1, nw - 1, nw - 1, 0, vb.t0);
    finishFrame("b2b second", 1'b1, 2'b10, {14'd0, 4'h0, 16'h0B0B, 30'h00BB}, base, 2);

    // EOP on the seqid word itself (w=18 for untagged IPv4) is too early to report.
    base = pulse_cnt;
    buildFrame(vecs[0]);
    driveRange(0, 18, 18, 0, vecs[0].t0);
    finishFrame("eop on seqid", 1'b0, 2'b00, 64'd0, base, 0);

    // A SOP+EOP word after a frame reached MATCH restarts and ends the parse without a report.
    base = pulse_cnt;
    buildFrame(vecs[0]);
    driveRange(0, 18, -1, 0, vecs[0].t0);
    driveWord(fw[0], 1'b1, 1'b1, 30'h0999);
    finishFrame("sop+eop", 1'b0, 2'b00, 64'd0, base, 0);

    // Reset after the frame matched: remaining words including EOP must not report.
    base = pulse_cnt;
    buildFrame(vecs[0]);
    driveRange(0, 18, -1, 0, vecs[0].t0);
    @(negedge clk);
    rst = 1'b1;
    bus.ptp_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midrst found", {63'd0, bus.ptp_found}, 64'd0);
    checkOutput("midrst infor", {14'd0, bus.ptp_infor}, 64'd0);
    driveRange(19, nw - 1, nw - 1, 0, vecs[0].t0);
    finishFrame("midrst", 1'b0, 2'b00, 64'd0, base, 0);

    // The parser still works after all corner cases.
    applyStimulus(99, vecs[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
